// File: rtl/dmem_mmio_pkg.sv
// rtl/dmem_mmio_pkg.sv - shared encodings for the data-memory / MMIO subsystem
//
// Purpose : DMType access codes, MMIO register offsets, CTRL bit positions
//           and small access-size helpers shared by dmem_mmio and dmem_timer.
// Ports   : none (package)
package dmem_mmio_pkg;

  // DMType access codes driven by the CPU MEM stage
  localparam logic [2:0] DM_WORD = 3'b000;
  localparam logic [2:0] DM_HALF = 3'b001;
  localparam logic [2:0] DM_HALFU = 3'b010;
  localparam logic [2:0] DM_BYTE = 3'b011;
  localparam logic [2:0] DM_BYTEU = 3'b100;

  // Byte offsets inside the 64-byte peripheral window
  localparam logic [5:0] OFF_LED = 6'h00;
  localparam logic [5:0] OFF_SW = 6'h04;
  localparam logic [5:0] OFF_CYCLE = 6'h08;
  localparam logic [5:0] OFF_CMP = 6'h0C;
  localparam logic [5:0] OFF_CTRL = 6'h10;
  localparam logic [5:0] OFF_TCNT = 6'h14;

  // CTRL register bit positions
  localparam int CTRL_EN = 0;
  localparam int CTRL_PEND = 1;
  localparam int CTRL_IE = 2;

  function automatic logic dm_is_half(input logic [2:0] t);
    return (t == DM_HALF) || (t == DM_HALFU);
  endfunction

  function automatic logic dm_is_byte(input logic [2:0] t);
    return (t == DM_BYTE) || (t == DM_BYTEU);
  endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// rtl/dmem_mmio_if.sv - CPU MEM-stage to data-memory bus
//
// Purpose : groups the MEM-stage access signals into one bundle.
// Signals : mem_w    store strobe
//           Addr_in  byte address
//           Data_in  store data
//           DMType   access type
//           Data_out extended load data (combinational)
//           misalign current access is misaligned (combinational)
// Modports: master = CPU side, slave = memory side.
interface dmem_mmio_if;
  logic        mem_w;
  logic [31:0] Addr_in;
  logic [31:0] Data_in;
  logic [2:0]  DMType;
  logic [31:0] Data_out;
  logic        misalign;

  modport master (
    output mem_w, Addr_in, Data_in, DMType,
    input  Data_out, misalign
  );

  modport slave (
    input  mem_w, Addr_in, Data_in, DMType,
    output Data_out, misalign
  );
endinterface

// File: rtl/dmem_timer.sv
// rtl/dmem_timer.sv - cycle counter and compare timer with interrupt
//
// Purpose : holds CYCLE, CMP, CTRL (EN/PEND/IE) and TCNT, and drives the
//           registered timer interrupt level.
// Ports   : clk, reset (async active-low)
//           wr_en, wr_off, wr_data : word register write (already qualified)
//           rd_off, rd_data        : combinational register read
//           irq                    : PEND & IE, registered
module dmem_timer
  import dmem_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [5:0]  wr_off,
  input  logic [31:0] wr_data,
  input  logic [5:0]  rd_off,
  output logic [31:0] rd_data,
  output logic        irq
);

  logic [31:0] cycle, cmp, tcnt;
  logic        en, pend, ie;

  logic [31:0] cmp_n, tcnt_n;
  logic        en_n, pend_n, ie_n;
  logic        match, wr_cmp, wr_ctrl, wr_tcnt;

  always_comb begin
    wr_cmp  = wr_en && (wr_off == OFF_CMP);
    wr_ctrl = wr_en && (wr_off == OFF_CTRL);
    wr_tcnt = wr_en && (wr_off == OFF_TCNT);
    // Compare uses the registered CMP, so a CMP write is seen next cycle
    match   = en && (tcnt == cmp);

    tcnt_n = tcnt;
    if (wr_tcnt)    tcnt_n = wr_data;
    else if (match) tcnt_n = 32'd0;
    else if (en)    tcnt_n = tcnt + 32'd1;

    cmp_n = wr_cmp ? wr_data : cmp;
    en_n  = wr_ctrl ? wr_data[CTRL_EN] : en;
    ie_n  = wr_ctrl ? wr_data[CTRL_IE] : ie;

    // A new match beats a simultaneous write-1-to-clear
    pend_n = pend;
    if (match)                             pend_n = 1'b1;
    else if (wr_ctrl && wr_data[CTRL_PEND]) pend_n = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle <= 32'd0;
      cmp   <= 32'hFFFF_FFFF;
      tcnt  <= 32'd0;
      en    <= 1'b0;
      pend  <= 1'b0;
      ie    <= 1'b0;
      irq   <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;
      cmp   <= cmp_n;
      tcnt  <= tcnt_n;
      en    <= en_n;
      pend  <= pend_n;
      ie    <= ie_n;
      irq   <= pend_n & ie_n;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (rd_off)
      OFF_CYCLE: rd_data = cycle;
      OFF_CMP:   rd_data = cmp;
      OFF_CTRL:  rd_data = {29'd0, ie, pend, en};
      OFF_TCNT:  rd_data = tcnt;
      default:   rd_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data RAM plus memory-mapped peripheral window
//
// Purpose : zero-latency data memory for the MEM stage with sub-word
//           load extension, byte-lane stores, misalignment detection and a
//           64-byte MMIO window (LED, SW, CYCLE, CMP, CTRL, TCNT).
// Ports   : clk, reset (async active-low)
//           bus       : dmem_mmio_if.slave (mem_w, Addr_in, Data_in, DMType,
//                       Data_out, misalign)
//           sw_in     : asynchronous switch inputs
//           led_out   : LED register
//           irq_timer : timer interrupt level
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          SW_W        = 16
) (
  input  logic            clk,
  input  logic            reset,
  dmem_mmio_if.slave      bus,
  input  logic [SW_W-1:0] sw_in,
  output logic [SW_W-1:0] led_out,
  output logic            irq_timer
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]     ram [DEPTH_WORDS];
  logic [SW_W-1:0] led, sw_s1, sw_s2;

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          is_half, is_byte, is_word, is_mmio;
  logic          ram_we, mmio_we;
  logic [5:0]    mmio_off;
  logic [3:0]    be;
  logic [31:0]   wdata, rd_word, mmio_rd, timer_rd;
  logic [15:0]   lane_h;
  logic [7:0]    lane_b;

  assign idx      = bus.Addr_in[AW+1:2];
  assign lane     = bus.Addr_in[1:0];
  assign is_half  = dm_is_half(bus.DMType);
  assign is_byte  = dm_is_byte(bus.DMType);
  // Unused DMType codes fall through to word accesses
  assign is_word  = !is_half && !is_byte;
  assign is_mmio  = (bus.Addr_in[31:6] == MMIO_BASE[31:6]);
  assign mmio_off = {bus.Addr_in[5:2], 2'b00};

  assign bus.misalign = (is_half && lane[0]) || (is_word && (lane != 2'b00));

  assign ram_we  = bus.mem_w && !bus.misalign && !is_mmio;
  // Peripheral registers only accept full-word stores
  assign mmio_we = bus.mem_w && !bus.misalign && is_mmio && is_word;

  // Store lane merge: replicate data across lanes, enable only the addressed ones
  always_comb begin
    be    = 4'b1111;
    wdata = bus.Data_in;
    if (is_byte) begin
      be    = 4'b0001 << lane;
      wdata = {4{bus.Data_in[7:0]}};
    end else if (is_half) begin
      be    = lane[1] ? 4'b1100 : 4'b0011;
      wdata = {2{bus.Data_in[15:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led   <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;
      if (mmio_we && (mmio_off == OFF_LED)) led <= bus.Data_in[SW_W-1:0];
    end
  end

  assign led_out = led;

  dmem_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (mmio_we),
    .wr_off  (mmio_off),
    .wr_data (bus.Data_in),
    .rd_off  (mmio_off),
    .rd_data (timer_rd),
    .irq     (irq_timer)
  );

  // The timer returns 0 for offsets it does not own, covering unmapped reads
  always_comb begin
    mmio_rd = timer_rd;
    if (mmio_off == OFF_LED)     mmio_rd = {{(32-SW_W){1'b0}}, led};
    else if (mmio_off == OFF_SW) mmio_rd = {{(32-SW_W){1'b0}}, sw_s2};
  end

  // Load extraction: pick the lane, then sign- or zero-extend
  always_comb begin
    rd_word = is_mmio ? mmio_rd : ram[idx];
    lane_h  = lane[1] ? rd_word[31:16] : rd_word[15:0];
    lane_b  = rd_word[8*lane +: 8];
    bus.Data_out = rd_word;
    case (bus.DMType)
      DM_HALF:  bus.Data_out = {{16{lane_h[15]}}, lane_h};
      DM_HALFU: bus.Data_out = {16'd0, lane_h};
      DM_BYTE:  bus.Data_out = {{24{lane_b[7]}}, lane_b};
      DM_BYTEU: bus.Data_out = {24'd0, lane_b};
      default:  bus.Data_out = rd_word;
    endcase
    if (bus.misalign) bus.Data_out = 32'd0;
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - directed self-checking bench for dmem_mmio
//
// Purpose : drives RAM loads/stores, misalignment, LED/SW, timer and async
//           reset scenarios and compares against hand-computed values.
// Ports   : none (top-level bench)
module tb_dmem_mmio;
  import dmem_mmio_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        irq_timer;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] d;

  dmem_mmio_if bus ();

  dmem_mmio #(
    .DEPTH_WORDS (1024),
    .MMIO_BASE   (BASE),
    .SW_W        (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .irq_timer (irq_timer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] dat, input logic [2:0] t);
    bus.mem_w   = 1'b1;
    bus.Addr_in = a;
    bus.Data_in = dat;
    bus.DMType  = t;
    @(posedge clk);
    #1;
    bus.mem_w = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] t, output logic [31:0] q);
    bus.mem_w   = 1'b0;
    bus.Addr_in = a;
    bus.DMType  = t;
    #1;
    q = bus.Data_out;
  endtask

  initial begin
    reset       = 1'b0;
    sw_in       = 16'h0000;
    bus.mem_w   = 1'b0;
    bus.Addr_in = 32'd0;
    bus.Data_in = 32'd0;
    bus.DMType  = DM_WORD;
    #1;
    chk("rst_led", {16'd0, led_out}, 32'd0);
    chk("rst_irq", {31'd0, irq_timer}, 32'd0);
    tick(2);
    @(negedge clk);
    reset = 1'b1;
    tick(1);

    // RAM word store then sub-word loads
    store(32'h100, 32'h8765_4321, DM_WORD);
    load(32'h101, DM_BYTE, d);   chk("lb_101", d, 32'h0000_0043);
    load(32'h101, DM_BYTEU, d);  chk("lbu_101", d, 32'h0000_0043);
    load(32'h102, DM_HALF, d);   chk("lh_102", d, 32'hFFFF_8765);
    load(32'h102, DM_HALFU, d);  chk("lhu_102", d, 32'h0000_8765);
    load(32'h103, DM_BYTE, d);   chk("lb_103", d, 32'hFFFF_FF87);
    chk("mis_byte", {31'd0, bus.misalign}, 32'd0);

    // Byte store merge, misaligned half store suppressed
    store(32'h103, 32'h0000_00AA, DM_BYTE);
    load(32'h100, DM_WORD, d);   chk("lw_after_sb", d, 32'hAA65_4321);
    bus.mem_w   = 1'b1;
    bus.Addr_in = 32'h101;
    bus.Data_in = 32'h0000_1234;
    bus.DMType  = DM_HALF;
    #1;
    chk("mis_sh", {31'd0, bus.misalign}, 32'd1);
    chk("mis_dout", bus.Data_out, 32'd0);
    @(posedge clk);
    #1;
    bus.mem_w = 1'b0;
    load(32'h100, DM_WORD, d);   chk("lw_after_mis", d, 32'hAA65_4321);
    load(32'h102, DM_WORD, d);
    chk("mis_lw", {31'd0, bus.misalign}, 32'd1);
    chk("mis_lw_dout", d, 32'd0);
    load(32'h1100, DM_WORD, d);  chk("alias", d, 32'hAA65_4321);

    // LED register
    store(BASE + 32'h00, 32'h0000_5A5A, DM_WORD);
    chk("led_sw", {16'd0, led_out}, 32'h0000_5A5A);
    store(BASE + 32'h00, 32'h0000_0000, DM_BYTE);
    chk("led_sb", {16'd0, led_out}, 32'h0000_5A5A);
    load(BASE + 32'h01, DM_BYTEU, d); chk("led_lbu", d, 32'h0000_005A);
    load(BASE + 32'h20, DM_WORD, d);  chk("unmapped", d, 32'd0);

    // Switch synchroniser: two edges of latency
    sw_in = 16'h00F0;
    tick(1);
    load(BASE + 32'h04, DM_WORD, d); chk("sw_1cyc", d, 32'd0);
    tick(1);
    load(BASE + 32'h04, DM_WORD, d); chk("sw_2cyc", d, 32'h0000_00F0);

    // Timer: CMP=5, EN+IE, match six edges after EN
    store(BASE + 32'h0C, 32'd5, DM_WORD);
    store(BASE + 32'h10, 32'h5, DM_WORD);
    load(BASE + 32'h14, DM_WORD, d); chk("tcnt_start", d, 32'd0);
    tick(5);
    chk("irq_pre", {31'd0, irq_timer}, 32'd0);
    load(BASE + 32'h10, DM_WORD, d); chk("ctrl_pre", d, 32'h5);
    tick(1);
    chk("irq_match", {31'd0, irq_timer}, 32'd1);
    load(BASE + 32'h10, DM_WORD, d); chk("ctrl_match", d, 32'h7);
    load(BASE + 32'h14, DM_WORD, d); chk("tcnt_reload", d, 32'd0);
    tick(5);
    store(BASE + 32'h10, 32'h7, DM_WORD);
    chk("irq_w1c_match", {31'd0, irq_timer}, 32'd1);
    load(BASE + 32'h10, DM_WORD, d); chk("ctrl_w1c_match", d, 32'h7);
    store(BASE + 32'h10, 32'h7, DM_WORD);
    chk("irq_w1c", {31'd0, irq_timer}, 32'd0);
    load(BASE + 32'h10, DM_WORD, d); chk("ctrl_w1c", d, 32'h5);
    store(BASE + 32'h14, 32'd5, DM_WORD);
    load(BASE + 32'h14, DM_WORD, d); chk("tcnt_wr_wins", d, 32'd5);
    tick(1);
    chk("irq_tcnt_wr", {31'd0, irq_timer}, 32'd1);

    // Asynchronous reset mid-count
    #2;
    reset = 1'b0;
    #1;
    chk("arst_led", {16'd0, led_out}, 32'd0);
    chk("arst_irq", {31'd0, irq_timer}, 32'd0);
    load(BASE + 32'h08, DM_WORD, d); chk("arst_cycle", d, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    load(BASE + 32'h0C, DM_WORD, d); chk("cmp_reset", d, 32'hFFFF_FFFF);
    load(BASE + 32'h10, DM_WORD, d); chk("ctrl_reset", d, 32'd0);
    tick(1);
    load(BASE + 32'h08, DM_WORD, d); chk("cycle_1", d, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
